clk_reset_sequencer: RTL and testbench
======================================

Name: clk_reset_sequencer

Overview:
- Sits directly downstream of the main PLL wrapper, in the PLL clk0 domain (50 MHz × CLOCK_MULTIPLIER).
- Consumes the PLL's asynchronous pll_locked and sequences reset release across the whole system:
  - PLL lock stability filter.
  - SDRAM power-up delay.
  - Memory-controller reset release.
  - CPU reset release after the SDRAM controller reports init done.
- Any lock loss re-enters the full sequence.

Parameters:
- CLK_FREQ_MHZ, 100: clk frequency in MHz; scales the power-up delay.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before leaving LOCK_WAIT; ≥2.
- PWRUP_US, 200: SDRAM power-up wait in µs; PWRUP_CYCLES = PWRUP_US*CLK_FREQ_MHZ.
- INIT_TIMEOUT_CYCLES, 65536: maximum INIT_WAIT duration before retry.
- SYNC_STAGES, 2: pll_locked synchronizer depth; ≥2.

Ports:
- clk  in  1  system clock (PLL c0).
- reset  in  1  synchronous, active-high sequencer reset (board/JTAG request).
- pll_locked  in  1  PLL lock, asynchronous to clk.
- sdram_init_done  in  1  SDRAM controller init-complete level, synchronous to clk.
- mem_reset  out  1  synchronous active-high reset to SDRAM controller.
- cpu_reset  out  1  synchronous active-high reset to RISC-V core and peripherals.
- pwrup_done  out  1  high once the power-up delay has elapsed in the current sequence.
- init_timeout  out  1  sticky: at least one INIT_WAIT timeout since reset.
- lock_loss_cnt  out  8  saturating count of post-filter lock losses.
- seq_state  out  3  current state code, for JTAG debug readback.

Behaviour:
- Synchronizer:
  - pll_locked passes through SYNC_STAGES flops to form locked_s.
  - All synchronizer flops reset to 0.
- Reset values:
  - seq_state = HOLD, mem_reset = 1, cpu_reset = 1.
  - pwrup_done = 0, init_timeout = 0, lock_loss_cnt = 0.
  - All counters 0.
- Output decode:
  - Outputs are registered and change in the same cycle as seq_state.
  - mem_reset = 1 in HOLD, LOCK_WAIT and PWRUP_WAIT.
  - pwrup_done = 1 in INIT_WAIT and RUN.
  - cpu_reset = 0 only in RUN.
- States: HOLD = 0, LOCK_WAIT = 1, PWRUP_WAIT = 2, INIT_WAIT = 3, RUN = 4.
- HOLD:
  - Counter is held at 0.
  - locked_s = 1 → LOCK_WAIT on the next cycle.
- LOCK_WAIT:
  - Counter increments each cycle.
  - locked_s = 0 → HOLD; this is a glitch, so lock_loss_cnt is not incremented.
  - After exactly LOCK_STABLE_CYCLES cycles in LOCK_WAIT → PWRUP_WAIT, counter cleared.
- PWRUP_WAIT:
  - Lasts exactly PWRUP_CYCLES cycles, then → INIT_WAIT, counter cleared.
- INIT_WAIT:
  - sdram_init_done = 1 → RUN on the next cycle.
  - Otherwise, after INIT_TIMEOUT_CYCLES cycles → HOLD, and init_timeout is set to 1.
- RUN: terminal while locked.
- Lock loss:
  - Applies when locked_s = 0 in PWRUP_WAIT, INIT_WAIT or RUN.
  - → HOLD on the next cycle.
  - lock_loss_cnt increments by 1 and saturates at 255.
- Priority, highest first:
  1. reset
  2. lock loss
  3. sdram_init_done
  4. timeout or counter expiry
- Reset mid-sequence:
  - Returns to HOLD with all reset values, including clearing init_timeout and lock_loss_cnt.
  - Synchronizer flops are reset too, so re-lock takes SYNC_STAGES+1 cycles to reach LOCK_WAIT.
- Counter:
  - Single shared counter, width $clog2 of max(LOCK_STABLE_CYCLES, PWRUP_CYCLES, INIT_TIMEOUT_CYCLES) + 1.
  - Compared against (limit − 1); no wrap-around occurs.
- sdram_init_done outside INIT_WAIT is ignored.
- Latency from pll_locked rising to LOCK_WAIT: SYNC_STAGES+1 cycles.

Decomposition:
- Shared package clk_reset_pkg:
  - State encoding constants (SEQ_HOLD … SEQ_RUN).
  - LOSS_CNT_W = 8.
  - Counter-width helper function.
- Sub-module sync_bit:
  - Parameterised SYNC_STAGES-deep single-bit synchronizer with synchronous reset.
  - Reused for other asynchronous inputs.

Test Plan:
All scenarios use SYNC_STAGES = 2, LOCK_STABLE_CYCLES = 8, CLK_FREQ_MHZ = 1, PWRUP_US = 16, INIT_TIMEOUT_CYCLES = 32. Cycle 0 is the first cycle after reset release.
1. Bring-up timing:
   - Stimulus: pll_locked = 1 from cycle 0.
   - Response: seq_state = 1 at cycle 3; seq_state = 2 at cycle 11; seq_state = 3 at cycle 27 with mem_reset = 0 and pwrup_done = 1; cpu_reset stays 1.
2. Init handshake:
   - Stimulus: continuing 1, sdram_init_done = 1 at cycle 30.
   - Response: seq_state = 4 and cpu_reset = 0 at cycle 31.
3. Lock glitch:
   - Stimulus: one-cycle pll_locked low during LOCK_WAIT.
   - Response: return to HOLD; lock_loss_cnt = 0; the next LOCK_WAIT requires a full 8 cycles.
4. Lock loss in RUN:
   - Stimulus: pll_locked drops while in RUN.
   - Response: HOLD within 3 cycles; cpu_reset = 1, mem_reset = 1, lock_loss_cnt = 1.
   - Stimulus: 300 repeated losses.
   - Response: lock_loss_cnt = 255.
5. Init timeout:
   - Stimulus: sdram_init_done never asserted.
   - Response: INIT_WAIT lasts 32 cycles, then HOLD with init_timeout = 1.
   - Stimulus: next sequence succeeds.
   - Response: RUN is reached and init_timeout stays 1.
6. Simultaneous events:
   - Stimulus: reset asserted in the same cycle as sdram_init_done in INIT_WAIT.
   - Response: next cycle is HOLD with all reset values.
   - Stimulus: locked_s = 0 in the same cycle as sdram_init_done.
   - Response: HOLD, not RUN.

Source files
------------

// File: rtl/clk_reset_pkg.sv
// Shared definitions for the clock/reset sequencer: state encoding,
// lock-loss counter width and the shared-counter width helper.
package clk_reset_pkg;

  localparam int SEQ_W      = 3;
  localparam int LOSS_CNT_W = 8;

  // Reset-release sequence states; codes are visible on seq_state for debug.
  typedef enum logic [SEQ_W-1:0] {
    SEQ_HOLD       = 3'd0,
    SEQ_LOCK_WAIT  = 3'd1,
    SEQ_PWRUP_WAIT = 3'd2,
    SEQ_INIT_WAIT  = 3'd3,
    SEQ_RUN        = 3'd4
  } seq_state_e;

  // Width of one counter able to hold the largest of three cycle limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_reset_sequencer_sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous reset. The chain
// clears to 0 on reset so an asynchronous "good" level must be re-observed
// for the full depth before it is believed.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Next value of each stage: stage 0 samples the raw input, later stages shift.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer chain register.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_reset_sequencer.sv
// System reset-release sequencer in the PLL c0 domain. Filters PLL lock,
// waits out the SDRAM power-up time, releases the memory controller, then
// releases the CPU once SDRAM init completes. Any post-filter lock loss
// restarts the whole sequence.
import clk_reset_pkg::*;

module clk_reset_sequencer #(
  parameter int CLK_FREQ_MHZ        = 100,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int PWRUP_US            = 200,
  parameter int INIT_TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  sdram_init_done,
  output logic                  mem_reset,
  output logic                  cpu_reset,
  output logic                  pwrup_done,
  output logic                  init_timeout,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [SEQ_W-1:0]      seq_state
);

  localparam int PWRUP_CYCLES = PWRUP_US * CLK_FREQ_MHZ;
  localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, PWRUP_CYCLES, INIT_TIMEOUT_CYCLES);

  // Terminal counts: a phase of N cycles ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_TIMEOUT_CYCLES - 1);

  logic locked_s;

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_reset_q, mem_reset_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  pwrup_done_q, pwrup_done_d;
  logic                  init_timeout_q, init_timeout_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  lock_loss;

  sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .srst (reset),
    .d    (pll_locked),
    .q    (locked_s)
  );

  // Next-state, shared counter, sticky flags and registered output decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    init_timeout_d = init_timeout_q;
    loss_cnt_d     = loss_cnt_q;
    lock_loss      = 1'b0;

    unique case (state_q)
      SEQ_HOLD: begin
        cnt_d = '0;
        if (locked_s) state_d = SEQ_LOCK_WAIT;
      end
      SEQ_LOCK_WAIT: begin
        // A drop here is a pre-filter glitch and is not counted as a loss.
        if (!locked_s) begin
          state_d = SEQ_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = SEQ_PWRUP_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEQ_PWRUP_WAIT: begin
        if (!locked_s) begin
          state_d   = SEQ_HOLD;
          cnt_d     = '0;
          lock_loss = 1'b1;
        end else if (cnt_q == PWRUP_LAST) begin
          state_d = SEQ_INIT_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEQ_INIT_WAIT: begin
        // Lock loss beats init-done, which beats the timeout.
        if (!locked_s) begin
          state_d   = SEQ_HOLD;
          cnt_d     = '0;
          lock_loss = 1'b1;
        end else if (sdram_init_done) begin
          state_d = SEQ_RUN;
          cnt_d   = '0;
        end else if (cnt_q == INIT_LAST) begin
          state_d        = SEQ_HOLD;
          cnt_d          = '0;
          init_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEQ_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d   = SEQ_HOLD;
          lock_loss = 1'b1;
        end
      end
      default: begin
        state_d = SEQ_HOLD;
        cnt_d   = '0;
      end
    endcase

    if (lock_loss && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    end

    // Decode from the next state so outputs move together with seq_state.
    mem_reset_d  = (state_d == SEQ_HOLD) || (state_d == SEQ_LOCK_WAIT) ||
                   (state_d == SEQ_PWRUP_WAIT);
    pwrup_done_d = (state_d == SEQ_INIT_WAIT) || (state_d == SEQ_RUN);
    cpu_reset_d  = (state_d != SEQ_RUN);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SEQ_HOLD;
      cnt_q          <= '0;
      mem_reset_q    <= 1'b1;
      cpu_reset_q    <= 1'b1;
      pwrup_done_q   <= 1'b0;
      init_timeout_q <= 1'b0;
      loss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_reset_q    <= mem_reset_d;
      cpu_reset_q    <= cpu_reset_d;
      pwrup_done_q   <= pwrup_done_d;
      init_timeout_q <= init_timeout_d;
      loss_cnt_q     <= loss_cnt_d;
    end
  end

  assign seq_state     = state_q;
  assign mem_reset     = mem_reset_q;
  assign cpu_reset     = cpu_reset_q;
  assign pwrup_done    = pwrup_done_q;
  assign init_timeout  = init_timeout_q;
  assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Directed bench for clk_reset_sequencer. Cycle 0 is the first cycle after
// the last edge that sampled reset high; inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_clk_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sdram_init_done = 1'b0;
  logic       mem_reset, cpu_reset, pwrup_done, init_timeout;
  logic [7:0] lock_loss_cnt;
  logic [2:0] seq_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  clk_reset_sequencer #(
    .CLK_FREQ_MHZ        (1),
    .LOCK_STABLE_CYCLES  (8),
    .PWRUP_US            (16),
    .INIT_TIMEOUT_CYCLES (32),
    .SYNC_STAGES         (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .sdram_init_done (sdram_init_done),
    .mem_reset       (mem_reset),
    .cpu_reset       (cpu_reset),
    .pwrup_done      (pwrup_done),
    .init_timeout    (init_timeout),
    .lock_loss_cnt   (lock_loss_cnt),
    .seq_state       (seq_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  // Hold reset for three edges; returns in cycle 0 with reset released.
  task automatic apply_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    sdram_init_done = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (seq_state === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b1;
    repeat (3) step();
    checks++;
    if (seq_state !== 3'd0 || mem_reset !== 1'b1 || cpu_reset !== 1'b1 ||
        pwrup_done !== 1'b0 || init_timeout !== 1'b0 || lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d mem=%b cpu=%b pwr=%b to=%b loss=%0d, want 0 1 1 0 0 0",
               seq_state, mem_reset, cpu_reset, pwrup_done, init_timeout, lock_loss_cnt);
    end
    $display("test_reset: state=%0d mem=%b cpu=%b", seq_state, mem_reset, cpu_reset);
  endtask

  task automatic test_bringup();
    apply_reset();
    pll_locked = 1'b1;
    step_to(2);
    checks++;
    if (seq_state !== 3'd0) begin
      errors++; $display("FAIL bringup_c2: state=%0d want 0", seq_state);
    end
    step_to(3);
    checks++;
    if (seq_state !== 3'd1 || mem_reset !== 1'b1) begin
      errors++; $display("FAIL bringup_c3: state=%0d mem=%b want 1 1", seq_state, mem_reset);
    end
    step_to(10);
    checks++;
    if (seq_state !== 3'd1) begin
      errors++; $display("FAIL bringup_c10: state=%0d want 1", seq_state);
    end
    step_to(11);
    checks++;
    if (seq_state !== 3'd2 || mem_reset !== 1'b1 || pwrup_done !== 1'b0) begin
      errors++; $display("FAIL bringup_c11: state=%0d mem=%b pwr=%b want 2 1 0", seq_state, mem_reset, pwrup_done);
    end
    // init_done outside INIT_WAIT must be ignored
    sdram_init_done = 1'b1;
    step_to(26);
    checks++;
    if (seq_state !== 3'd2 || pwrup_done !== 1'b0) begin
      errors++; $display("FAIL ignore_init_done_c26: state=%0d pwr=%b want 2 0", seq_state, pwrup_done);
    end
    sdram_init_done = 1'b0;
    step_to(27);
    checks++;
    if (seq_state !== 3'd3 || mem_reset !== 1'b0 || pwrup_done !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL bringup_c27: state=%0d mem=%b pwr=%b cpu=%b want 3 0 1 1",
                         seq_state, mem_reset, pwrup_done, cpu_reset);
    end
    $display("test_bringup: cycle=%0d state=%0d", cyc, seq_state);
  endtask

  // Continues directly from test_bringup at cycle 27.
  task automatic test_init_handshake();
    step_to(30);
    checks++;
    if (seq_state !== 3'd3 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL init_c30: state=%0d cpu=%b want 3 1", seq_state, cpu_reset);
    end
    sdram_init_done = 1'b1;
    step_to(31);
    checks++;
    if (seq_state !== 3'd4 || cpu_reset !== 1'b0 || mem_reset !== 1'b0 || pwrup_done !== 1'b1) begin
      errors++; $display("FAIL init_c31: state=%0d cpu=%b mem=%b pwr=%b want 4 0 0 1",
                         seq_state, cpu_reset, mem_reset, pwrup_done);
    end
    sdram_init_done = 1'b0;
    step_to(40);
    checks++;
    if (seq_state !== 3'd4) begin
      errors++; $display("FAIL run_hold_c40: state=%0d want 4", seq_state);
    end
    $display("test_init_handshake: cycle=%0d state=%0d cpu=%b", cyc, seq_state, cpu_reset);
  endtask

  task automatic test_lock_glitch();
    apply_reset();
    pll_locked = 1'b1;
    step_to(5);
    pll_locked = 1'b0;
    step_to(6);
    pll_locked = 1'b1;
    step_to(7);
    checks++;
    if (seq_state !== 3'd1) begin
      errors++; $display("FAIL glitch_c7: state=%0d want 1", seq_state);
    end
    step_to(8);
    checks++;
    if (seq_state !== 3'd0 || lock_loss_cnt !== 8'd0) begin
      errors++; $display("FAIL glitch_c8: state=%0d loss=%0d want 0 0", seq_state, lock_loss_cnt);
    end
    step_to(16);
    checks++;
    if (seq_state !== 3'd1) begin
      errors++; $display("FAIL glitch_relock_c16: state=%0d want 1", seq_state);
    end
    step_to(17);
    checks++;
    if (seq_state !== 3'd2 || lock_loss_cnt !== 8'd0) begin
      errors++; $display("FAIL glitch_relock_c17: state=%0d loss=%0d want 2 0", seq_state, lock_loss_cnt);
    end
    $display("test_lock_glitch: cycle=%0d state=%0d loss=%0d", cyc, seq_state, lock_loss_cnt);
  endtask

  task automatic test_lock_loss();
    bit ok;
    apply_reset();
    pll_locked = 1'b1;
    step_to(30);
    sdram_init_done = 1'b1;
    step_to(31);
    sdram_init_done = 1'b0;
    pll_locked = 1'b0;
    step_to(33);
    checks++;
    if (seq_state !== 3'd4) begin
      errors++; $display("FAIL loss_run_c33: state=%0d want 4", seq_state);
    end
    step_to(34);
    checks++;
    if (seq_state !== 3'd0 || cpu_reset !== 1'b1 || mem_reset !== 1'b1 ||
        pwrup_done !== 1'b0 || lock_loss_cnt !== 8'd1) begin
      errors++; $display("FAIL loss_run_c34: state=%0d cpu=%b mem=%b pwr=%b loss=%0d want 0 1 1 0 1",
                         seq_state, cpu_reset, mem_reset, pwrup_done, lock_loss_cnt);
    end
    $display("test_lock_loss: first loss state=%0d loss=%0d", seq_state, lock_loss_cnt);
    // 299 further losses, each taken in PWRUP_WAIT
    for (int n = 2; n <= 300; n++) begin
      pll_locked = 1'b1;
      wait_state(3'd2, 40, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL loss_loop_reach_pwrup: n=%0d state=%0d want 2", n, seq_state);
        break;
      end
      pll_locked = 1'b0;
      wait_state(3'd0, 10, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL loss_loop_reach_hold: n=%0d state=%0d want 0", n, seq_state);
        break;
      end
      if (n == 100) begin
        checks++;
        if (lock_loss_cnt !== 8'd100) begin
          errors++; $display("FAIL loss_cnt_100: got %0d want 100", lock_loss_cnt);
        end
      end
      if (n == 255) begin
        checks++;
        if (lock_loss_cnt !== 8'd255) begin
          errors++; $display("FAIL loss_cnt_255: got %0d want 255", lock_loss_cnt);
        end
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin
      errors++; $display("FAIL loss_cnt_sat: got %0d want 255", lock_loss_cnt);
    end
    $display("test_lock_loss: after 300 losses loss=%0d", lock_loss_cnt);
  endtask

  task automatic test_init_timeout();
    apply_reset();
    checks++;
    if (lock_loss_cnt !== 8'd0 || init_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_after_reset: loss=%0d to=%b want 0 0", lock_loss_cnt, init_timeout);
    end
    pll_locked = 1'b1;
    step_to(58);
    checks++;
    if (seq_state !== 3'd3 || init_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_c58: state=%0d to=%b want 3 0", seq_state, init_timeout);
    end
    step_to(59);
    checks++;
    if (seq_state !== 3'd0 || init_timeout !== 1'b1 || mem_reset !== 1'b1 || lock_loss_cnt !== 8'd0) begin
      errors++; $display("FAIL timeout_c59: state=%0d to=%b mem=%b loss=%0d want 0 1 1 0",
                         seq_state, init_timeout, mem_reset, lock_loss_cnt);
    end
    step_to(83);
    checks++;
    if (seq_state !== 3'd2) begin
      errors++; $display("FAIL retry_c83: state=%0d want 2", seq_state);
    end
    step_to(84);
    sdram_init_done = 1'b1;
    step_to(85);
    sdram_init_done = 1'b0;
    checks++;
    if (seq_state !== 3'd4 || init_timeout !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++; $display("FAIL retry_run_c85: state=%0d to=%b cpu=%b want 4 1 0", seq_state, init_timeout, cpu_reset);
    end
    $display("test_init_timeout: cycle=%0d state=%0d to=%b", cyc, seq_state, init_timeout);
  endtask

  task automatic test_simultaneous();
    // reset together with init_done in INIT_WAIT (after a timeout set the sticky flag)
    apply_reset();
    pll_locked = 1'b1;
    step_to(84);
    reset = 1'b1;
    sdram_init_done = 1'b1;
    step_to(85);
    checks++;
    if (seq_state !== 3'd0 || mem_reset !== 1'b1 || cpu_reset !== 1'b1 || pwrup_done !== 1'b0 ||
        init_timeout !== 1'b0 || lock_loss_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_vs_init_done: state=%0d mem=%b cpu=%b pwr=%b to=%b loss=%0d want 0 1 1 0 0 0",
                         seq_state, mem_reset, cpu_reset, pwrup_done, init_timeout, lock_loss_cnt);
    end
    $display("test_simultaneous: reset+init_done state=%0d", seq_state);
    // lock loss together with init_done in INIT_WAIT
    apply_reset();
    pll_locked = 1'b1;
    step_to(27);
    pll_locked = 1'b0;
    step_to(29);
    sdram_init_done = 1'b1;
    step_to(30);
    sdram_init_done = 1'b0;
    checks++;
    if (seq_state !== 3'd0 || cpu_reset !== 1'b1 || lock_loss_cnt !== 8'd1) begin
      errors++; $display("FAIL loss_vs_init_done: state=%0d cpu=%b loss=%0d want 0 1 1",
                         seq_state, cpu_reset, lock_loss_cnt);
    end
    $display("test_simultaneous: loss+init_done state=%0d loss=%0d", seq_state, lock_loss_cnt);
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_init_handshake();
    test_lock_glitch();
    test_lock_loss();
    test_init_timeout();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
